// File: rtl/fdau_pkg.sv
// Shared FSM encoding, frame-size arithmetic and parameter legality check for the FDAU frame builder.
package fdau_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ADC_WAIT = 3'd1,
    S_ADC_LOW  = 3'd2,
    S_CNT      = 3'd3,
    S_DIG_ADDR = 3'd4,
    S_DIG_WR   = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  function automatic int frame_words(input int adc_words, input int num_cnt,
                                     input int num_dig, input int dig_words);
    return adc_words + num_cnt + num_dig * dig_words;
  endfunction

  function automatic bit params_ok(input int adc_words, input int num_cnt,
                                   input int num_dig, input int dig_words, input int aw);
    bit pow2;
    pow2 = (dig_words > 0) && ((dig_words & (dig_words - 1)) == 0);
    return (adc_words >= 1) && (adc_words <= 255) &&
           (num_cnt >= 0) && (num_cnt <= 8) &&
           (num_dig >= 1) && (num_dig <= 8) &&
           pow2 && (dig_words <= 256) &&
           (aw >= 1) && (aw <= 24) &&
           (frame_words(adc_words, num_cnt, num_dig, dig_words) <= (1 << aw));
  endfunction

endpackage

// File: rtl/fdau_frame_ram.sv
// Ping-pong frame store: one write port, one registered read port, single clock.
module fdau_frame_ram #(
  parameter int AW = 9
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [AW:0] wr_addr,
  input  logic [15:0] wr_data,
  input  logic [AW:0] rd_addr,
  output logic [15:0] rd_q
);

  logic [15:0] mem [0:(1 << (AW + 1)) - 1];

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) rd_q <= 16'h0000;
    else       rd_q <= mem[rd_addr];
  end

endmodule

// File: rtl/fdau_frame_builder.sv
// Builds one frame per accepted sec pulse (ADC samples, counter snapshot, digital channel words)
// into the write half of a ping-pong RAM; the host reads the other, last completed half.
module fdau_frame_builder
  import fdau_pkg::*;
#(
  parameter int ADC_WORDS = 65,
  parameter int NUM_CNT   = 3,
  parameter int NUM_DIG   = 6,
  parameter int DIG_WORDS = 32,
  parameter int AW        = 9
) (
  input  logic                                         clock,
  input  logic                                         reset,
  input  logic                                         sec,
  input  logic                                         adc_rdy,
  input  logic [15:0]                                  adc_data,
  input  logic [16*((NUM_CNT > 0) ? NUM_CNT : 1)-1:0]  cnt_data,
  input  logic [NUM_DIG-1:0]                           ch_enable,
  output logic [2:0]                                   dig_sel,
  output logic [7:0]                                   dig_addr,
  input  logic [15:0]                                  dig_data,
  input  logic [AW-1:0]                                rd_addr,
  output logic [15:0]                                  rd_q,
  output logic                                         rd_bank,
  output logic                                         frame_ready,
  output logic                                         busy,
  output logic                                         overrun
);

  if (!params_ok(ADC_WORDS, NUM_CNT, NUM_DIG, DIG_WORDS, AW)) begin : g_param_check
    $error("fdau_frame_builder: illegal parameter set");
  end

  localparam logic [7:0] ADC_LAST = 8'(ADC_WORDS);
  localparam logic [2:0] CNT_LAST = 3'(NUM_CNT - 1);
  localparam logic [3:0] CH_LAST  = 4'(NUM_DIG - 1);
  localparam logic [7:0] WD_LAST  = 8'(DIG_WORDS - 1);

  state_t           state_q, state_d;
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [AW-1:0]    offset_q, offset_d;
  logic [7:0]       adc_cnt_q, adc_cnt_d;
  logic [2:0]       cnt_idx_q, cnt_idx_d;
  logic [3:0]       ch_idx_q, ch_idx_d;
  logic [7:0]       word_idx_q, word_idx_d;
  logic [7:0][15:0] snap_q, snap_d;
  logic [7:0]       en_q, en_d;
  logic [2:0]       dig_sel_q, dig_sel_d;
  logic [7:0]       dig_addr_q, dig_addr_d;
  logic             frame_ready_q, frame_ready_d;
  logic             overrun_q, overrun_d;

  logic             wr_en;
  logic [15:0]      wr_data;

  always_comb begin
    state_d       = state_q;
    wr_bank_d     = wr_bank_q;
    rd_bank_d     = rd_bank_q;
    offset_d      = offset_q;
    adc_cnt_d     = adc_cnt_q;
    cnt_idx_d     = cnt_idx_q;
    ch_idx_d      = ch_idx_q;
    word_idx_d    = word_idx_q;
    snap_d        = snap_q;
    en_d          = en_q;
    dig_sel_d     = dig_sel_q;
    dig_addr_d    = dig_addr_q;
    frame_ready_d = 1'b0;
    overrun_d     = overrun_q | (sec & (state_q != S_IDLE));
    wr_en         = 1'b0;
    wr_data       = 16'h0000;

    case (state_q)
      S_IDLE: begin
        if (sec) begin
          for (int i = 0; i < NUM_CNT; i++) snap_d[3'(i)] = cnt_data[16*i +: 16];
          en_d                = '0;
          en_d[NUM_DIG-1:0]   = ch_enable;
          offset_d            = '0;
          adc_cnt_d           = '0;
          cnt_idx_d           = '0;
          ch_idx_d            = '0;
          word_idx_d          = '0;
          state_d             = S_ADC_WAIT;
        end
      end
      S_ADC_WAIT: begin
        if (adc_rdy) begin
          wr_en     = 1'b1;
          wr_data   = adc_data;
          offset_d  = offset_q + AW'(1);
          adc_cnt_d = adc_cnt_q + 8'(1);
          state_d   = S_ADC_LOW;
        end
      end
      // Waiting for the strobe to drop is what makes a long-held sample count once.
      S_ADC_LOW: begin
        if (!adc_rdy) begin
          if (adc_cnt_q == ADC_LAST) state_d = (NUM_CNT > 0) ? S_CNT : S_DIG_ADDR;
          else                       state_d = S_ADC_WAIT;
        end
      end
      S_CNT: begin
        wr_en     = 1'b1;
        wr_data   = snap_q[cnt_idx_q];
        offset_d  = offset_q + AW'(1);
        cnt_idx_d = cnt_idx_q + 3'(1);
        if (cnt_idx_q == CNT_LAST) state_d = S_DIG_ADDR;
      end
      S_DIG_ADDR: begin
        dig_sel_d  = ch_idx_q[2:0];
        dig_addr_d = word_idx_q;
        state_d    = S_DIG_WR;
      end
      S_DIG_WR: begin
        wr_en    = 1'b1;
        wr_data  = en_q[ch_idx_q[2:0]] ? dig_data : 16'h0000;
        offset_d = offset_q + AW'(1);
        state_d  = S_DIG_ADDR;
        if (word_idx_q == WD_LAST) begin
          word_idx_d = '0;
          ch_idx_d   = ch_idx_q + 4'(1);
          if (ch_idx_q == CH_LAST) state_d = S_DONE;
        end else begin
          word_idx_d = word_idx_q + 8'(1);
        end
      end
      S_DONE: begin
        wr_bank_d     = ~wr_bank_q;
        rd_bank_d     = wr_bank_q;
        frame_ready_d = 1'b1;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b1;
      offset_q      <= '0;
      adc_cnt_q     <= '0;
      cnt_idx_q     <= '0;
      ch_idx_q      <= '0;
      word_idx_q    <= '0;
      snap_q        <= '0;
      en_q          <= '0;
      dig_sel_q     <= '0;
      dig_addr_q    <= '0;
      frame_ready_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_bank_q     <= wr_bank_d;
      rd_bank_q     <= rd_bank_d;
      offset_q      <= offset_d;
      adc_cnt_q     <= adc_cnt_d;
      cnt_idx_q     <= cnt_idx_d;
      ch_idx_q      <= ch_idx_d;
      word_idx_q    <= word_idx_d;
      snap_q        <= snap_d;
      en_q          <= en_d;
      dig_sel_q     <= dig_sel_d;
      dig_addr_q    <= dig_addr_d;
      frame_ready_q <= frame_ready_d;
      overrun_q     <= overrun_d;
    end
  end

  fdau_frame_ram #(.AW(AW)) u_ram (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr ({wr_bank_q, offset_q}),
    .wr_data (wr_data),
    .rd_addr ({rd_bank_q, rd_addr}),
    .rd_q    (rd_q)
  );

  assign dig_sel     = dig_sel_q;
  assign dig_addr    = dig_addr_q;
  assign rd_bank     = rd_bank_q;
  assign frame_ready = frame_ready_q;
  assign busy        = (state_q != S_IDLE);
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_fdau_frame_builder.sv
// Frame builder bench: table of frame scenarios plus random frames, checked against a frame-level model.
module tb_fdau_frame_builder;

  localparam int ADC_W   = 4;
  localparam int N_CNT   = 3;
  localparam int N_DIG   = 2;
  localparam int DIG_W   = 4;
  localparam int AW      = 5;
  localparam int FW      = ADC_W + N_CNT + N_DIG * DIG_W;
  // clocks from the last ADC strobe drop to frame_ready: ADC_LOW exit, counter words, 2/word, DONE
  localparam int DIG_LAT = 1 + N_CNT + 2 * N_DIG * DIG_W + 1;

  typedef struct packed {
    logic [3:0][15:0] smp;
    logic [2:0][15:0] cnt;
    logic [1:0]       en;
    logic [15:0]      salt;
    int               hold;
    int               simult;
    int               ovr_a;
    int               ovr_b;
    int               abort_at;
    bit               has_exp;
    bit               exp_rb;
    bit               exp_ovr;
  } vec_t;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              sec = 1'b0;
  logic              adc_rdy = 1'b0;
  logic [15:0]       adc_data = 16'h0;
  logic [47:0]       cnt_data = 48'h0;
  logic [1:0]        ch_enable = 2'b00;
  logic [2:0]        dig_sel;
  logic [7:0]        dig_addr;
  logic [15:0]       dig_data;
  logic [AW-1:0]     rd_addr = '0;
  logic [15:0]       rd_q;
  logic              rd_bank, frame_ready, busy, overrun;
  logic [15:0]       salt = 16'h0;

  logic [15:0]       mem_m [2][FW];
  bit                valid_m [2];
  bit                wb_m, rb_m, ovr_m, chk_rd;
  logic [15:0]       exp_f [FW];
  vec_t              tbl [6];
  int                vectors = 0;
  int                miscompares = 0;

  always #5 clock = ~clock;

  // channel word source: {D, 0, sel, addr} optionally scrambled per frame
  assign dig_data = {8'hD0, 1'b0, dig_sel, dig_addr[3:0]} ^ salt;

  fdau_frame_builder #(
    .ADC_WORDS(ADC_W), .NUM_CNT(N_CNT), .NUM_DIG(N_DIG), .DIG_WORDS(DIG_W), .AW(AW)
  ) dut (
    .clock(clock), .reset(reset), .sec(sec), .adc_rdy(adc_rdy), .adc_data(adc_data),
    .cnt_data(cnt_data), .ch_enable(ch_enable), .dig_sel(dig_sel), .dig_addr(dig_addr),
    .dig_data(dig_data), .rd_addr(rd_addr), .rd_q(rd_q), .rd_bank(rd_bank),
    .frame_ready(frame_ready), .busy(busy), .overrun(overrun)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    bit pb;
    logic [AW-1:0] pa;
    bit en;
    pb = rb_m;
    pa = rd_addr;
    en = chk_rd && valid_m[pb];
    @(posedge clock);
    #1;
    if (en) chk("rd_q", 32'(rd_q), 32'(mem_m[pb][pa]));
  endtask

  task automatic tickr();
    rd_addr = AW'($urandom_range(0, FW - 1));
    tick();
  endtask

  function automatic vec_t mk(input logic [63:0] smp, input logic [47:0] cnt, input logic [1:0] en,
                              input logic [15:0] sl, input int hold, input int simult,
                              input int oa, input int ob, input int ab,
                              input bit has_exp, input bit exp_rb, input bit exp_ovr);
    vec_t v;
    v.smp = smp; v.cnt = cnt; v.en = en; v.salt = sl; v.hold = hold; v.simult = simult;
    v.ovr_a = oa; v.ovr_b = ob; v.abort_at = ab;
    v.has_exp = has_exp; v.exp_rb = exp_rb; v.exp_ovr = exp_ovr;
    return v;
  endfunction

  task automatic run_frame(input vec_t v);
    for (int k = 0; k < ADC_W; k++) exp_f[k] = v.smp[k];
    for (int k = 0; k < N_CNT; k++) exp_f[ADC_W + k] = v.cnt[k];
    for (int c = 0; c < N_DIG; c++)
      for (int w = 0; w < DIG_W; w++)
        exp_f[ADC_W + N_CNT + c * DIG_W + w] = v.en[c] ? ((16'hD000 | 16'(c * 16 + w)) ^ v.salt) : 16'h0;

    cnt_data = v.cnt; ch_enable = v.en; salt = v.salt; sec = 1'b1;
    if (v.simult != 0) begin adc_rdy = 1'b1; adc_data = v.smp[0]; end
    tickr();
    sec = 1'b0;
    // later changes must not leak into the frame already started
    cnt_data = ~v.cnt; ch_enable = ~v.en;
    chk("busy_start", 32'(busy), 32'(1));

    for (int k = 0; k < ADC_W; k++) begin
      adc_data = v.smp[k]; adc_rdy = 1'b1;
      repeat ((k == 0) ? v.hold : 1) tickr();
      adc_rdy = 1'b0; adc_data = 16'($urandom);
      if (k != ADC_W - 1) repeat (1 + (k % 2)) tickr();
    end

    for (int i = 1; i <= DIG_LAT + 6; i++) begin
      sec = (i == v.ovr_a) || (i == v.ovr_b);
      if (sec) ovr_m = 1'b1;
      tickr();
      if (v.abort_at != 0 && i == v.abort_at) begin
        reset = 1'b1; chk_rd = 1'b0; sec = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_frame_ready", 32'(frame_ready), 32'(0));
        chk("rst_overrun", 32'(overrun), 32'(0));
        chk("rst_rd_bank", 32'(rd_bank), 32'(1));
        chk("rst_dig_sel", 32'(dig_sel), 32'(0));
        chk("rst_dig_addr", 32'(dig_addr), 32'(0));
        chk("rst_rd_q", 32'(rd_q), 32'(0));
        for (int k = 0; k < ADC_W + i - 1; k++) mem_m[wb_m][k] = exp_f[k];
        wb_m = 1'b0; rb_m = 1'b1; ovr_m = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0; chk_rd = 1'b1;
        for (int j = 0; j < DIG_LAT + 4; j++) begin
          tickr();
          chk("abort_no_ready", 32'(frame_ready), 32'(0));
          chk("abort_idle", 32'(busy), 32'(0));
        end
        return;
      end
      if (i == DIG_LAT) begin
        for (int k = 0; k < FW; k++) mem_m[wb_m][k] = exp_f[k];
        valid_m[wb_m] = 1'b1; rb_m = wb_m; wb_m = ~wb_m;
      end
      chk("frame_ready", 32'(frame_ready), 32'(i == DIG_LAT));
      chk("busy", 32'(busy), 32'(i < DIG_LAT));
      chk("rd_bank", 32'(rd_bank), 32'(rb_m));
    end
    sec = 1'b0;
    chk("overrun", 32'(overrun), 32'(ovr_m));
    if (v.has_exp) begin
      chk("tbl_rd_bank", 32'(rd_bank), 32'(v.exp_rb));
      chk("tbl_overrun", 32'(overrun), 32'(v.exp_ovr));
    end
    for (int a = 0; a < FW; a++) begin rd_addr = AW'(a); tick(); end
    tick();
  endtask

  initial begin
    vec_t v;
    wb_m = 1'b0; rb_m = 1'b1; ovr_m = 1'b0; chk_rd = 1'b0;
    valid_m[0] = 1'b0; valid_m[1] = 1'b0;

    tbl[0] = mk({16'h0104, 16'h0103, 16'h0102, 16'h0101}, {16'h0C03, 16'h0C02, 16'h0C01},
                2'b11, 16'h0, 1, 0, 0, 0, 0, 1'b1, 1'b0, 1'b0);
    tbl[1] = mk({16'h0204, 16'h0203, 16'h0202, 16'h0201}, {16'h0C06, 16'h0C05, 16'h0C04},
                2'b11, 16'h0, 2, 1, 0, 0, 0, 1'b1, 1'b1, 1'b0);
    tbl[2] = mk({16'h0304, 16'h0303, 16'h0302, 16'h0301}, {16'h0C09, 16'h0C08, 16'h0C07},
                2'b10, 16'h0, 1, 0, 0, 0, 0, 1'b1, 1'b0, 1'b0);
    tbl[3] = mk({16'h0404, 16'h0403, 16'h0402, 16'h0401}, {16'h0C0C, 16'h0C0B, 16'h0C0A},
                2'b11, 16'h0, 5, 0, 0, 0, 0, 1'b1, 1'b1, 1'b0);
    tbl[4] = mk({16'h0504, 16'h0503, 16'h0502, 16'h0501}, {16'h0C0F, 16'h0C0E, 16'h0C0D},
                2'b01, 16'h0, 1, 0, 20, DIG_LAT, 0, 1'b1, 1'b0, 1'b1);
    tbl[5] = mk({16'h0704, 16'h0703, 16'h0702, 16'h0701}, {16'h0C13, 16'h0C12, 16'h0C11},
                2'b11, 16'h0, 1, 1, 0, 0, 0, 1'b1, 1'b0, 1'b0);

    repeat (2) @(posedge clock);
    #1;
    chk("reset_busy", 32'(busy), 32'(0));
    chk("reset_frame_ready", 32'(frame_ready), 32'(0));
    chk("reset_overrun", 32'(overrun), 32'(0));
    chk("reset_rd_bank", 32'(rd_bank), 32'(1));
    chk("reset_dig_sel", 32'(dig_sel), 32'(0));
    chk("reset_dig_addr", 32'(dig_addr), 32'(0));
    chk("reset_rd_q", 32'(rd_q), 32'(0));
    reset = 1'b0; chk_rd = 1'b1;
    tick();

    for (int t = 0; t < 5; t++) begin
      run_frame(tbl[t]);
      if (t == 0) begin
        rd_addr = AW'(7);  tick(); chk("basic_off7", 32'(rd_q), 32'(16'hD000));
        rd_addr = AW'(14); tick(); chk("basic_off14", 32'(rd_q), 32'(16'hD013));
        rd_addr = AW'(4);  tick(); chk("basic_off4", 32'(rd_q), 32'(16'h0C01));
      end
      if (t == 2) begin
        rd_addr = AW'(8);  tick(); chk("en_off8", 32'(rd_q), 32'(16'h0000));
        rd_addr = AW'(12); tick(); chk("en_off12", 32'(rd_q), 32'(16'hD011));
      end
    end

    // abort a frame while counter words are being written, then rebuild into bank 0
    v = mk({16'h0604, 16'h0603, 16'h0602, 16'h0601}, {16'h0C10, 16'h0C10, 16'h0C10},
           2'b11, 16'h0, 1, 0, 0, 0, 2, 1'b0, 1'b0, 1'b0);
    run_frame(v);
    run_frame(tbl[5]);

    for (int r = 0; r < 20; r++) begin
      v = mk({$urandom, $urandom}, {16'($urandom), $urandom}, 2'($urandom), 16'($urandom),
             int'($urandom_range(1, 5)), int'($urandom_range(0, 1)),
             ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, DIG_LAT)) : 0,
             0, 0, 1'b0, 1'b0, 1'b0);
      run_frame(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
